// File: rtl/tetris_pkg.sv
// Shared field constants, op/state encodings and the 4x4 clockwise rotation helper.
package tetris_pkg;

    localparam int FIELD_W = 10;
    localparam int FIELD_H = 20;
    localparam int BOX_N   = 4;

    localparam logic [3:0] X_MAX = 4'd15;
    localparam logic [4:0] Y_MAX = 5'd31;

    typedef enum logic [2:0] {
        OP_SPAWN = 3'd0,
        OP_DOWN  = 3'd1,
        OP_ROT   = 3'd2,
        OP_LEFT  = 3'd3,
        OP_RIGHT = 3'd4
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_EVAL   = 3'd2,
        S_KICK_L = 3'd3,
        S_KICK_R = 3'd4,
        S_OVER   = 3'd5
    } state_e;

    // Pattern bit r*4+c, bit 0 = top-left; clockwise: new[r][c] = old[3-c][r].
    function automatic logic [15:0] rotate_cw(input logic [15:0] f);
        logic [15:0] r_f;
        r_f = '0;
        for (int r = 0; r < BOX_N; r++) begin
            for (int c = 0; c < BOX_N; c++) begin
                r_f[r*BOX_N + c] = f[(BOX_N-1-c)*BOX_N + r];
            end
        end
        return r_f;
    endfunction

endpackage

// File: rtl/piece_rotator.sv
// Combinational clockwise rotation of a 4x4 piece pattern.
module piece_rotator
    import tetris_pkg::*;
(
    input  logic [15:0] float_i,
    output logic [15:0] float_o
);

    assign float_o = rotate_cw(float_i);

endmodule

// File: rtl/piece_move_controller.sv
// Sequences the shared collision checker for spawn/move/rotate/drop of the falling piece.
// Optional macro WALL_KICK_EN: a blocked rotation is retried at x-1, then x+1.
//
// state  | meaning
// IDLE   | pick highest-priority pending op, register candidate into chk_*
// WAIT   | hold chk_* stable for CHECK_LAT cycles
// EVAL   | sample chk_collision, commit or reject
// KICK_L | (WALL_KICK_EN) set up rotated candidate at x-1
// KICK_R | (WALL_KICK_EN) set up rotated candidate at x+1
// OVER   | spawn collided; terminal until reset
module piece_move_controller
    import tetris_pkg::*;
#(
    parameter int         CHECK_LAT = 1,
    parameter logic [3:0] SPAWN_X   = 4'd3,
    parameter logic [4:0] SPAWN_Y   = 5'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spawn_req,
    input  logic [15:0] spawn_float,
    input  logic        left_req,
    input  logic        right_req,
    input  logic        rot_req,
    input  logic        down_req,
    input  logic        tick,
    output logic [3:0]  chk_x,
    output logic [4:0]  chk_y,
    output logic [15:0] chk_float,
    input  logic        chk_collision,
    output logic [3:0]  cur_x,
    output logic [4:0]  cur_y,
    output logic [15:0] cur_float,
    output logic        piece_active,
    output logic        lock_pulse,
    output logic        game_over,
    output logic        busy
);

    localparam logic [2:0] ST_IDLE = S_IDLE;
    localparam logic [2:0] ST_WAIT = S_WAIT;
    localparam logic [2:0] ST_EVAL = S_EVAL;
    localparam logic [2:0] ST_OVER = S_OVER;
`ifdef WALL_KICK_EN
    localparam logic [2:0] ST_KICK_L = S_KICK_L;
    localparam logic [2:0] ST_KICK_R = S_KICK_R;
`endif

    localparam logic [1:0] LAT_M1 = (CHECK_LAT > 0) ? 2'(CHECK_LAT - 1) : 2'd0;

    logic [2:0]  state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [3:0]  chk_x_q, chk_x_d;
    logic [4:0]  chk_y_q, chk_y_d;
    logic [15:0] chk_float_q, chk_float_d;
    logic [3:0]  cur_x_q, cur_x_d;
    logic [4:0]  cur_y_q, cur_y_d;
    logic [15:0] cur_float_q, cur_float_d;
    logic        piece_active_q, piece_active_d;
    logic        lock_pulse_q, lock_pulse_d;
    logic        game_over_q, game_over_d;
    logic [15:0] spawn_float_q, spawn_float_d;
    logic        pend_spawn_q, pend_spawn_d;
    logic        pend_down_q, pend_down_d;
    logic        pend_rot_q, pend_rot_d;
    logic        pend_left_q, pend_left_d;
    logic        pend_right_q, pend_right_d;
`ifdef WALL_KICK_EN
    logic [1:0]  kick_q, kick_d;
`endif

    logic        clr_spawn, clr_down, clr_rot, clr_left, clr_right;
    logic        go_check;
    logic [15:0] rot_float;

    piece_rotator u_rotator (
        .float_i (cur_float_q),
        .float_o (rot_float)
    );

    // Strobes accumulate here; a strobe coinciding with its clear wins.
    always_comb begin
        pend_spawn_d  = (pend_spawn_q & ~clr_spawn) | spawn_req;
        spawn_float_d = spawn_float_q;
        if (spawn_req && !piece_active_q && !game_over_q) begin
            spawn_float_d = spawn_float;
        end
        if (piece_active_q || game_over_q) begin
            pend_spawn_d = 1'b0;
        end

        pend_down_d  = 1'b0;
        pend_rot_d   = 1'b0;
        pend_left_d  = 1'b0;
        pend_right_d = 1'b0;
        if (piece_active_q && !game_over_q) begin
            pend_down_d  = (pend_down_q  & ~clr_down)  | tick | down_req;
            pend_rot_d   = (pend_rot_q   & ~clr_rot)   | rot_req;
            pend_left_d  = (pend_left_q  & ~clr_left)  | left_req;
            pend_right_d = (pend_right_q & ~clr_right) | right_req;
        end
    end

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        cnt_d          = cnt_q;
        chk_x_d        = chk_x_q;
        chk_y_d        = chk_y_q;
        chk_float_d    = chk_float_q;
        cur_x_d        = cur_x_q;
        cur_y_d        = cur_y_q;
        cur_float_d    = cur_float_q;
        piece_active_d = piece_active_q;
        lock_pulse_d   = 1'b0;
        game_over_d    = game_over_q;
        clr_spawn      = 1'b0;
        clr_down       = 1'b0;
        clr_rot        = 1'b0;
        clr_left       = 1'b0;
        clr_right      = 1'b0;
        go_check       = 1'b0;
`ifdef WALL_KICK_EN
        kick_d         = kick_q;
`endif

        case (state_q)
            ST_IDLE: begin
`ifdef WALL_KICK_EN
                kick_d = 2'd0;
`endif
                if (pend_spawn_q && !piece_active_q && !game_over_q) begin
                    clr_spawn   = 1'b1;
                    op_d        = OP_SPAWN;
                    chk_x_d     = SPAWN_X;
                    chk_y_d     = SPAWN_Y;
                    chk_float_d = spawn_float_q;
                    go_check    = 1'b1;
                end else if (piece_active_q && pend_down_q) begin
                    clr_down = 1'b1;
                    if (cur_y_q == Y_MAX) begin
                        // Bottom of the addressable field: lock without asking the checker.
                        lock_pulse_d   = 1'b1;
                        piece_active_d = 1'b0;
                    end else begin
                        op_d        = OP_DOWN;
                        chk_x_d     = cur_x_q;
                        chk_y_d     = cur_y_q + 5'd1;
                        chk_float_d = cur_float_q;
                        go_check    = 1'b1;
                    end
                end else if (piece_active_q && pend_rot_q) begin
                    clr_rot     = 1'b1;
                    op_d        = OP_ROT;
                    chk_x_d     = cur_x_q;
                    chk_y_d     = cur_y_q;
                    chk_float_d = rot_float;
                    go_check    = 1'b1;
                end else if (piece_active_q && pend_left_q) begin
                    clr_left = 1'b1;
                    if (cur_x_q != 4'd0) begin
                        op_d        = OP_LEFT;
                        chk_x_d     = cur_x_q - 4'd1;
                        chk_y_d     = cur_y_q;
                        chk_float_d = cur_float_q;
                        go_check    = 1'b1;
                    end
                end else if (piece_active_q && pend_right_q) begin
                    clr_right = 1'b1;
                    if (cur_x_q != X_MAX) begin
                        op_d        = OP_RIGHT;
                        chk_x_d     = cur_x_q + 4'd1;
                        chk_y_d     = cur_y_q;
                        chk_float_d = cur_float_q;
                        go_check    = 1'b1;
                    end
                end
            end

            ST_WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d = ST_EVAL;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end

            ST_EVAL: begin
                state_d = ST_IDLE;
                if (!chk_collision) begin
                    cur_x_d     = chk_x_q;
                    cur_y_d     = chk_y_q;
                    cur_float_d = chk_float_q;
                    if (op_q == OP_SPAWN) begin
                        piece_active_d = 1'b1;
                    end
                end else if (op_q == OP_DOWN) begin
                    lock_pulse_d   = 1'b1;
                    piece_active_d = 1'b0;
                end else if (op_q == OP_SPAWN) begin
                    game_over_d = 1'b1;
                    state_d     = ST_OVER;
                end
`ifdef WALL_KICK_EN
                else if (op_q == OP_ROT) begin
                    if (kick_q == 2'd0) begin
                        state_d = ST_KICK_L;
                    end else if (kick_q == 2'd1) begin
                        state_d = ST_KICK_R;
                    end
                end
`endif
            end

`ifdef WALL_KICK_EN
            // chk_float still holds the rotated pattern; only x moves.
            ST_KICK_L: begin
                if (cur_x_q != 4'd0) begin
                    chk_x_d  = cur_x_q - 4'd1;
                    kick_d   = 2'd1;
                    go_check = 1'b1;
                end else begin
                    state_d = ST_KICK_R;
                end
            end

            ST_KICK_R: begin
                kick_d = 2'd2;
                if (cur_x_q != X_MAX) begin
                    chk_x_d  = cur_x_q + 4'd1;
                    go_check = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
`endif

            ST_OVER: begin
                state_d = ST_OVER;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (go_check) begin
            state_d = (CHECK_LAT == 0) ? ST_EVAL : ST_WAIT;
            cnt_d   = LAT_M1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            op_q           <= 3'd0;
            cnt_q          <= 2'd0;
            chk_x_q        <= 4'd0;
            chk_y_q        <= 5'd0;
            chk_float_q    <= 16'd0;
            cur_x_q        <= 4'd0;
            cur_y_q        <= 5'd0;
            cur_float_q    <= 16'd0;
            piece_active_q <= 1'b0;
            lock_pulse_q   <= 1'b0;
            game_over_q    <= 1'b0;
            spawn_float_q  <= 16'd0;
            pend_spawn_q   <= 1'b0;
            pend_down_q    <= 1'b0;
            pend_rot_q     <= 1'b0;
            pend_left_q    <= 1'b0;
            pend_right_q   <= 1'b0;
`ifdef WALL_KICK_EN
            kick_q         <= 2'd0;
`endif
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            cnt_q          <= cnt_d;
            chk_x_q        <= chk_x_d;
            chk_y_q        <= chk_y_d;
            chk_float_q    <= chk_float_d;
            cur_x_q        <= cur_x_d;
            cur_y_q        <= cur_y_d;
            cur_float_q    <= cur_float_d;
            piece_active_q <= piece_active_d;
            lock_pulse_q   <= lock_pulse_d;
            game_over_q    <= game_over_d;
            spawn_float_q  <= spawn_float_d;
            pend_spawn_q   <= pend_spawn_d;
            pend_down_q    <= pend_down_d;
            pend_rot_q     <= pend_rot_d;
            pend_left_q    <= pend_left_d;
            pend_right_q   <= pend_right_d;
`ifdef WALL_KICK_EN
            kick_q         <= kick_d;
`endif
        end
    end

    assign chk_x        = chk_x_q;
    assign chk_y        = chk_y_q;
    assign chk_float    = chk_float_q;
    assign cur_x        = cur_x_q;
    assign cur_y        = cur_y_q;
    assign cur_float    = cur_float_q;
    assign piece_active = piece_active_q;
    assign lock_pulse   = lock_pulse_q;
    assign game_over    = game_over_q;
    assign busy         = (state_q != ST_IDLE);

endmodule
